matrix_display_scheduler: RTL and testbench



---
 rtl/matrix_display_scheduler.sv | 99 +++++++++
 tb/tb_matrix_display_scheduler.sv | 111 +++++++++++
 2 files changed

// File: rtl/matrix_display_scheduler.sv
// matrix_display_scheduler: column scan and water/irrigation image sharing for the 5x7 matrix
//   clock, reset (sync, active-high), enable (scan enable)
//   water_valid, irrigation_valid, force_water -> mode_select (1 = water), column_enable (one-hot),
//   frame_done (pulse after each 3-column frame), blank (matrix dark)
//   Optional MATRIX_SCHED_BLINK_EN: alert blink of alternate frames while force_water holds water
module matrix_display_scheduler #(
    parameter int SCAN_DIV          = 50000,
    parameter int WATER_FRAMES      = 100,
    parameter int IRRIGATION_FRAMES = 100
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       water_valid,
    input  logic       irrigation_valid,
    input  logic       force_water,
    output logic       mode_select,
    output logic [2:0] column_enable,
    output logic       frame_done,
    output logic       blank
);
    localparam int PW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    localparam int MF = WATER_FRAMES > IRRIGATION_FRAMES ? WATER_FRAMES : IRRIGATION_FRAMES;
    localparam int CW = MF > 1 ? $clog2(MF) : 1;

    typedef enum logic [1:0] {IDLE, SHOW_WATER, SHOW_IRRIGATION} state_t;

    state_t          state, state_n;
    logic [PW-1:0]   pre;
    logic [1:0]      col;
    logic [CW-1:0]   cnt, cnt_n;
    logic            tick, wrap, blink_n;

    assign tick = enable && pre == PW'(SCAN_DIV - 1);
    assign wrap = tick && col == 2'd2;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (wrap) begin
            case (state)
                IDLE:
                    state_n = water_valid ? SHOW_WATER : irrigation_valid ? SHOW_IRRIGATION : IDLE;
                SHOW_WATER:
                    if (force_water) cnt_n = '0;
                    else if (!water_valid) state_n = irrigation_valid ? SHOW_IRRIGATION : IDLE;
                    else if (cnt == CW'(WATER_FRAMES - 1)) begin
                        if (irrigation_valid) state_n = SHOW_IRRIGATION;
                        else cnt_n = '0;
                    end
                    else cnt_n = cnt + CW'(1);
                SHOW_IRRIGATION:
                    if (force_water && water_valid) state_n = SHOW_WATER;
                    else if (!irrigation_valid) state_n = water_valid ? SHOW_WATER : IDLE;
                    else if (cnt == CW'(IRRIGATION_FRAMES - 1)) begin
                        if (water_valid) state_n = SHOW_WATER;
                        else cnt_n = '0;
                    end
                    else cnt_n = cnt + CW'(1);
                default: state_n = IDLE;
            endcase
        end
        if (state_n != state) cnt_n = '0;
    end

`ifdef MATRIX_SCHED_BLINK_EN
    logic blink;
    // toggles only on frames that both start and end in forced water mode
    always_comb blink_n = (state_n == SHOW_WATER && force_water) ? blink ^ (wrap && state == SHOW_WATER) : 1'b0;
    always_ff @(posedge clock) begin
        if (reset) blink <= 1'b0;
        else blink <= blink_n;
    end
`else
    assign blink_n = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            pre           <= '0;
            col           <= '0;
            mode_select   <= 1'b1;
            column_enable <= '0;
            frame_done    <= 1'b0;
            blank         <= 1'b1;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            pre           <= (!enable || tick) ? '0 : pre + PW'(1);
            col           <= !enable ? 2'd0 : tick ? (col == 2'd2 ? 2'd0 : col + 2'd1) : col;
            mode_select   <= state_n != SHOW_IRRIGATION;
            column_enable <= enable ? 3'b001 << col : 3'b000;
            frame_done    <= wrap;
            blank         <= state_n == IDLE || !enable || blink_n;
        end
    end
endmodule

// File: tb/tb_matrix_display_scheduler.sv
// tb_matrix_display_scheduler: directed self-checking bench for matrix_display_scheduler
module tb_matrix_display_scheduler;
    logic       clock = 1'b0;
    logic       reset, enable, water_valid, irrigation_valid, force_water;
    logic       mode_select, frame_done, blank;
    logic [2:0] column_enable;
    int         n_checks = 0;
    int         n_err = 0;

    matrix_display_scheduler #(.SCAN_DIV(2), .WATER_FRAMES(2), .IRRIGATION_FRAMES(3)) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .water_valid(water_valid), .irrigation_valid(irrigation_valid), .force_water(force_water),
        .mode_select(mode_select), .column_enable(column_enable),
        .frame_done(frame_done), .blank(blank)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_fd(input string tag, input int cyc, input logic mode, input logic blk);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!frame_done && n < 20);
        check({tag, "_fd"}, frame_done, 1);
        if (cyc != 0) check({tag, "_cyc"}, n, cyc);
        check({tag, "_mode"}, mode_select, mode);
        check({tag, "_blank"}, blank, blk);
    endtask

    logic [2:0] ce [6] = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100};
    logic       seq [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        reset = 1'b1; enable = 1'b0; water_valid = 1'b0; irrigation_valid = 1'b0; force_water = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_mode", mode_select, 1);
        check("rst_col", column_enable, 0);
        check("rst_fd", frame_done, 0);
        check("rst_blank", blank, 1);
        reset = 1'b0; enable = 1'b1; water_valid = 1'b1; irrigation_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            check($sformatf("scan_col%0d", i), column_enable, ce[i]);
            check($sformatf("scan_fd%0d", i), frame_done, i == 5);
            check($sformatf("scan_blank%0d", i), blank, i != 5);
        end
        check("first_mode", mode_select, 1);
        for (int i = 0; i < 7; i++) wait_fd($sformatf("dwell%0d", i), 6, seq[i], 0);
        force_water = 1'b1;
        wait_fd("force_enter", 6, 1, 0);
        wait_fd("force_hold1", 6, 1, 0);
        wait_fd("force_hold2", 6, 1, 0);
        force_water = 1'b0;
        wait_fd("unforce_w", 6, 1, 0);
        wait_fd("unforce_i", 6, 0, 0);
        wait_fd("irr1", 6, 0, 0);
        wait_fd("irr2", 6, 0, 0);
        wait_fd("to_water", 6, 1, 0);
        water_valid = 1'b0; irrigation_valid = 1'b0;
        wait_fd("to_idle", 6, 1, 1);
        irrigation_valid = 1'b1;
        wait_fd("idle_to_irr", 6, 0, 0);
        water_valid = 1'b1; irrigation_valid = 1'b0;
        wait_fd("only_w0", 6, 1, 0);
        for (int i = 1; i < 5; i++) wait_fd($sformatf("only_w%0d", i), 6, 1, 0);
        @(negedge clock); check("pre_dis0", column_enable, 3'b001);
        @(negedge clock); check("pre_dis1", column_enable, 3'b001);
        @(negedge clock); check("pre_dis2", column_enable, 3'b010);
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check($sformatf("dis_col%0d", i), column_enable, 0);
            check($sformatf("dis_blank%0d", i), blank, 1);
            check($sformatf("dis_fd%0d", i), frame_done, 0);
        end
        enable = 1'b1;
        @(negedge clock); check("reen_col0", column_enable, 3'b001); check("reen_blank", blank, 0);
        @(negedge clock); check("reen_col1", column_enable, 3'b001);
        @(negedge clock); check("reen_col2", column_enable, 3'b010); check("reen_mode", mode_select, 1);
        wait_fd("reen_fd", 0, 1, 0);
        irrigation_valid = 1'b1;
        wait_fd("mid_irr", 6, 0, 0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("mrst_mode", mode_select, 1);
        check("mrst_col", column_enable, 0);
        check("mrst_fd", frame_done, 0);
        check("mrst_blank", blank, 1);
        reset = 1'b0;
        wait_fd("post_rst", 6, 1, 0);
`ifdef MATRIX_SCHED_BLINK_EN
        force_water = 1'b1;
        wait_fd("blink1", 6, 1, 1);
        wait_fd("blink2", 6, 1, 0);
        wait_fd("blink3", 6, 1, 1);
        force_water = 1'b0;
`endif
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
